// File: rtl/instructions_pkg.sv
// instructions_pkg: instruction and fetch-stage types shared by fetch and decode
package instructions_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_IMM    = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_REG    = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111,
        OP_SYSTEM = 7'b1110011
    } inst_type_e;

    typedef struct packed {
        logic [11:0] imm;
        logic [4:0]  rs1;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        inst_type_e  opcode;
    } i_type_t;

    typedef struct packed {
        logic [24:0] payload;
        inst_type_e  opcode;
    } instruction_t;

    typedef struct packed {
        logic [31:0]  pc;
        instruction_t inst;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        FLUSH
    } fetch_state_e;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return a & ~32'd3;
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// inst_fifo: synchronous FIFO with flush; push while full is accepted only together with a pop
//   clk, rst_n        clock, asynchronous active-low reset
//   flush_i           empties the FIFO on the next edge (wins over push/pop)
//   push_i, data_i    write side
//   pop_i, data_o     read side; data_o is the head entry
//   full_o, empty_o   status
//   count_o           number of stored entries (0..DEPTH)
module inst_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_q];
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(do_push);
            rd_q  <= rd_q + AW'(do_pop);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // storage needs no reset: reads of empty entries are masked by the user
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: sequential-PC fetch stage with credit-based instruction buffer and flush
//   clk, rst_n                          clock, asynchronous active-low reset
//   flush_i, flush_pc_i                 redirect pulse and target (low two bits ignored)
//   imem_req_valid_o/ready_i/addr_o     word read request to instruction memory
//   imem_rsp_valid_i/data_i             in-order read response (valid only)
//   inst_valid_o/ready_i, inst_o, pc_o  {pc, instruction} towards decode
module inst_fetch_unit
    import instructions_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic [31:0]  flush_pc_i,
    output logic         imem_req_valid_o,
    input  logic         imem_req_ready_i,
    output logic [31:0]  imem_req_addr_o,
    input  logic         imem_rsp_valid_i,
    input  logic [31:0]  imem_rsp_data_i,
    output logic         inst_valid_o,
    input  logic         inst_ready_i,
    output instruction_t inst_o,
    output logic [31:0]  pc_o
);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    // repeated flushes while draining can stack squashed reads beyond FIFO_DEPTH
    localparam int DROP_W = 16;

    fetch_state_e      state_q, state_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [CNT_W-1:0]  pcq_count, ibuf_count;
    logic [CNT_W:0]    in_use;
    logic              pcq_full, pcq_empty, ibuf_full, ibuf_empty;
    logic [31:0]       pcq_head;
    fetch_entry_t      ibuf_din, ibuf_head;
    logic              req_fire, rsp_keep, rsp_drop, inst_fire;

    // credit: each accepted read owns a buffer slot until its instruction is consumed
    assign in_use           = {1'b0, pcq_count} + {1'b0, ibuf_count};
    assign imem_req_valid_o = (state_q != IDLE) && !flush_i && (in_use < (CNT_W+1)'(FIFO_DEPTH));
    assign imem_req_addr_o  = fetch_pc_q;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;
    assign rsp_drop         = imem_rsp_valid_i && (drop_cnt_q != '0);
    assign rsp_keep         = imem_rsp_valid_i && (drop_cnt_q == '0);
    assign inst_fire        = inst_valid_o && inst_ready_i;
    assign ibuf_din         = '{pc: pcq_head, inst: instruction_t'(imem_rsp_data_i)};

    assign inst_valid_o = !ibuf_empty;
    assign inst_o       = ibuf_empty ? '0 : ibuf_head.inst;
    assign pc_o         = ibuf_empty ? '0 : ibuf_head.pc;

    inst_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_pcq (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush_i),
        .push_i  (req_fire),
        .data_i  (fetch_pc_q),
        .pop_i   (rsp_keep),
        .data_o  (pcq_head),
        .full_o  (pcq_full),
        .empty_o (pcq_empty),
        .count_o (pcq_count)
    );

    inst_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_ibuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush_i),
        .push_i  (rsp_keep && !flush_i),
        .data_i  (ibuf_din),
        .pop_i   (inst_fire),
        .data_o  (ibuf_head),
        .full_o  (ibuf_full),
        .empty_o (ibuf_empty),
        .count_o (ibuf_count)
    );

    // on flush every read still tracked in the PC queue becomes a drop; a response
    // arriving in the flush cycle is discarded either way, hence the net -1
    always_comb begin
        fetch_pc_d = flush_i  ? align_word(flush_pc_i)
                   : req_fire ? fetch_pc_q + 32'(WORD_BYTES)
                   : fetch_pc_q;
        drop_cnt_d = flush_i ? drop_cnt_q + DROP_W'(pcq_count) + DROP_W'(req_fire) - DROP_W'(imem_rsp_valid_i)
                   : drop_cnt_q - DROP_W'(rsp_drop);
        state_d    = (state_q == IDLE) ? FETCH : (drop_cnt_d != '0) ? FLUSH : FETCH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid_i |-> (drop_cnt_q != '0 || !pcq_empty));
    a_pcq_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        req_fire |-> !pcq_full);
    a_ibuf_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (rsp_keep && !flush_i) |-> (!ibuf_full || inst_fire));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed and randomised checks of inst_fetch_unit against a reference queue
module tb_inst_fetch_unit;
    import instructions_pkg::*;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush_i = 1'b0;
    logic [31:0]  flush_pc_i = '0;
    logic         imem_req_valid_o;
    logic         imem_req_ready_i = 1'b0;
    logic [31:0]  imem_req_addr_o;
    logic         imem_rsp_valid_i = 1'b0;
    logic [31:0]  imem_rsp_data_i = '0;
    logic         inst_valid_o;
    logic         inst_ready_i = 1'b0;
    instruction_t inst_o;
    logic [31:0]  pc_o;

    logic         b_req_valid;
    logic [31:0]  b_req_addr;
    logic         b_inst_valid;
    instruction_t b_inst;
    logic [31:0]  b_pc;

    int          n_chk = 0, n_fail = 0;
    int          cyc, n_req, n_out, first_valid_cyc;
    int          req_pct, inst_pct, lat_min, lat_max, flush_pct;
    logic        flush_req;
    logic [31:0] flush_tgt, exp_pc, first_out_pc;
    mreq_t       mq[$];
    logic [31:0] live[$];
    logic [31:0] b_addrs[$];

    always #5 clk = ~clk;

    inst_fetch_unit u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush_i          (flush_i),
        .flush_pc_i       (flush_pc_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .inst_valid_o     (inst_valid_o),
        .inst_ready_i     (inst_ready_i),
        .inst_o           (inst_o),
        .pc_o             (pc_o)
    );

    inst_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush_i          (1'b0),
        .flush_pc_i       (32'h0),
        .imem_req_valid_o (b_req_valid),
        .imem_req_ready_i (1'b1),
        .imem_req_addr_o  (b_req_addr),
        .imem_rsp_valid_i (1'b0),
        .imem_rsp_data_i  (32'h0),
        .inst_valid_o     (b_inst_valid),
        .inst_ready_i     (1'b1),
        .inst_o           (b_inst),
        .pc_o             (b_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        logic [31:0] e;
        @(negedge clk);
        cyc++;
        imem_req_ready_i = ($urandom_range(99) < req_pct);
        inst_ready_i     = ($urandom_range(99) < inst_pct);
        flush_i          = flush_req;
        flush_pc_i       = flush_tgt;
        flush_req        = 1'b0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rsp_valid_i = 1'b0;
            imem_rsp_data_i  = $urandom;
        end
        #1;
        if (inst_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (inst_valid_o && inst_ready_i) begin
            if (n_out == 0) first_out_pc = pc_o;
            n_out++;
            if (live.size() == 0) check("unexpected_out", 32'(inst_valid_o), 32'd0);
            else begin
                e = live.pop_front();
                check("out_pc", pc_o, e);
                check("out_inst", inst_o, mem_word(e));
            end
        end
        if (flush_i) begin
            live.delete();
            exp_pc = {flush_pc_i[31:2], 2'b00};
            check("req_valid_in_flush", 32'(imem_req_valid_o), 32'd0);
        end
        if (imem_req_valid_o && imem_req_ready_i) begin
            check("req_addr", imem_req_addr_o, exp_pc);
            live.push_back(exp_pc);
            mq.push_back('{addr: imem_req_addr_o, due: cyc + int'($urandom_range(lat_max, lat_min))});
            exp_pc += 32'd4;
            n_req++;
        end
        if (b_req_valid) b_addrs.push_back(b_req_addr);
        if (!flush_i && $urandom_range(99) < flush_pct) begin
            flush_req = 1'b1;
            flush_tgt = $urandom;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n            = 1'b0;
        flush_i          = 1'b0;
        flush_req        = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_req_ready_i = 1'b0;
        inst_ready_i     = 1'b0;
        mq.delete();
        live.delete();
        b_addrs.delete();
        exp_pc = 32'h0;
        #1;
        check({tag, "_req_valid"}, 32'(imem_req_valid_o), 32'd0);
        check({tag, "_req_addr"}, imem_req_addr_o, 32'h0);
        check({tag, "_inst_valid"}, 32'(inst_valid_o), 32'd0);
        check({tag, "_inst"}, inst_o, 32'h0);
        check({tag, "_pc"}, pc_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        n_req = 0;
        n_out = 0;
        first_valid_cyc = -1;
        first_out_pc = '1;
    endtask

    initial begin
        logic [31:0] wrap_exp [3];
        wrap_exp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        req_pct = 100; inst_pct = 100; lat_min = 1; lat_max = 1; flush_pct = 0;
        flush_req = 1'b0; flush_tgt = '0;

        // 1: streaming at full rate
        do_reset("rst1");
        run(10);
        check("t1_first_valid_cycle", 32'(first_valid_cyc), 32'd3);
        check("t1_n_req", 32'(n_req), 32'd10);
        check("t1_n_out", 32'(n_out), 32'd8);

        // 5: second instance starts near the top of the address space and wraps
        for (int i = 0; i < 3; i++)
            check("t5_wrap_addr", (i < b_addrs.size()) ? b_addrs[i] : 32'hxxxx_xxxx, wrap_exp[i]);

        // 2: decode stalled -> credit limit holds requests at FIFO_DEPTH
        do_reset("rst2");
        inst_pct = 0;
        run(20);
        check("t2_n_req", 32'(n_req), 32'd4);
        check("t2_req_valid_low", 32'(imem_req_valid_o), 32'd0);
        check("t2_head_pc", pc_o, 32'h0);
        check("t2_head_inst", inst_o, mem_word(32'h0));
        inst_pct = 100;
        run(4);
        check("t2_drained", 32'(n_out), 32'd4);
        run(6);
        check("t2_resume", 32'(n_req > 4), 32'd1);

        // 3: flush with three reads in flight
        do_reset("rst3");
        lat_min = 10; lat_max = 10;
        run(3);
        check("t3_inflight", 32'(n_req), 32'd3);
        flush_req = 1'b1; flush_tgt = 32'h0000_1003;
        step();
        run(30);
        check("t3_first_pc", first_out_pc, 32'h0000_1000);
        check("t3_some_out", 32'(n_out > 0), 32'd1);

        // 4: flush coincides with a response while memory is ready
        do_reset("rst4");
        lat_min = 2; lat_max = 2;
        run(2);
        flush_req = 1'b1; flush_tgt = 32'h0000_2000;
        step();
        run(20);
        check("t4_first_pc", first_out_pc, 32'h0000_2000);
        check("t4_no_hang", 32'(n_req > 4), 32'd1);

        // 6: random traffic and flushes, then drain with memory requests closed
        do_reset("rst6");
        req_pct = 70; inst_pct = 60; lat_min = 1; lat_max = 4; flush_pct = 4;
        run(600);
        flush_pct = 0; req_pct = 0; inst_pct = 100;
        step();
        run(30);
        check("t6_no_loss", 32'(live.size()), 32'd0);
        check("t6_empty", 32'(inst_valid_o), 32'd0);
        req_pct = 70; inst_pct = 60; flush_pct = 4;
        run(40);
        flush_pct = 0;
        do_reset("rst_mid");
        req_pct = 100; inst_pct = 100; lat_min = 1; lat_max = 1;
        run(8);
        check("t6_restart_first_valid", 32'(first_valid_cyc), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
